// File: rtl/dso_pkg.sv
// dso_pkg: shared op encodings, FSM states and frame length for the EEPROM SPI responder
package dso_pkg;
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_WP  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam int FRAME_LEN = 16;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: two-flop synchronizer with rise/fall detection on the synced level
// Ports: clk, rst_n (async active-low), d (async input), q (synced level),
//        rise/fall (one-clk pulses on synced edges). RST_VAL is the idle level.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s <= {3{RST_VAL}};
    else s <= {s[1:0], d};
  end
  assign q = s[1];
  assign rise = s[1] & ~s[2];
  assign fall = ~s[1] & s[2];
endmodule

// File: rtl/eep_spi_resp.sv
// eep_spi_resp: SPI mode-0 responder fronting a small byte-wide register EEPROM
// Ports: clk, rst_n (async active-low), SCLK/SS_n/MOSI (SPI from master, async),
//        MISO (high-Z outside a frame), frame_done/frame_err (one-clk pulses),
//        last_cmd (last accepted 16-bit command).
// Build option: define EEP_WP_EN to enable the write-protect op (op 10).
module eep_spi_resp
  import dso_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] last_cmd
);
  state_t state, state_nx;
  logic ss_q, ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_q;
  logic unused_sclk_q;
  logic [1:0] unused_mosi_edge;
  logic [1:0] settle;
  logic armed, start, accept, wr_blk;
  logic [4:0] cnt;
  logic [15:0] rx, tx;
  logic [7:0] resp, wp_resp;
  logic [7:0] mem [2**AW];
  logic [1:0] op;
  logic [AW-1:0] addr;
  logic [7:0] data;
  spi_edge_sync #(.RST_VAL(1'b1)) u_ss (.clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_q), .rise(ss_rise), .fall(ss_fall));
  spi_edge_sync #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rst_n(rst_n), .d(SCLK), .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_q), .rise(unused_mosi_edge[1]), .fall(unused_mosi_edge[0]));
  assign op = rx[15:14];
  assign addr = rx[8 +: AW];
  assign data = rx[7:0];
  assign MISO = (state == SHIFT) ? tx[15] : 1'bz;
`ifdef EEP_WP_EN
  logic wp;
  assign wr_blk = wp;
  assign wp_resp = {7'h0, data[0]};
`else
  assign wr_blk = 1'b0;
  assign wp_resp = 8'h00;
`endif
  // armed only after the synced SS_n has been seen high post-reset, so a
  // frame already in progress at reset release is never picked up mid-way
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? ((ss_fall && armed) ? SHIFT : IDLE) :
               (state == SHIFT) ? (ss_rise ? DONE : SHIFT) : IDLE;
    start = (state == IDLE) && (state_nx == SHIFT);
    accept = (state == DONE) && (cnt == 5'(FRAME_LEN));
    frame_done = accept;
    frame_err = (state == DONE) && !accept;
  end
  // a SCLK rise coincident with the SS_n rise is still taken in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      settle <= 2'b00;
      armed <= 1'b0;
      cnt <= 5'd0;
      rx <= 16'h0000;
      tx <= 16'h0000;
    end else begin
      state <= state_nx;
      settle <= {settle[0], 1'b1};
      armed <= armed | (settle[1] & ss_q);
      if (start) begin
        cnt <= 5'd0;
        tx <= {8'h00, resp};
      end else if (state == SHIFT) begin
        if (sclk_rise && cnt != 5'd31) cnt <= cnt + 5'd1;
        if (sclk_rise) rx <= {rx[14:0], mosi_q};
        if (sclk_fall) tx <= {tx[14:0], 1'b0};
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp <= 8'h00;
      last_cmd <= 16'h0000;
      for (int i = 0; i < 2**AW; i++) mem[i] <= 8'h00;
`ifdef EEP_WP_EN
      wp <= 1'b0;
`endif
    end else if (accept) begin
      last_cmd <= rx;
      resp <= (op == OP_RD) ? mem[addr] :
              (op == OP_WR) ? (wr_blk ? 8'hFF : data) :
              (op == OP_WP) ? wp_resp : 8'h00;
      if (op == OP_WR && !wr_blk) mem[addr] <= data;
`ifdef EEP_WP_EN
      if (op == OP_WP) wp <= data[0];
`endif
    end
  end
endmodule

// File: doc/eep_spi_resp.md
EEP_SPI_RESP -- requirements
Module: eep_spi_resp

Interface
REQ-001 SHALL have parameter AW, default 6, meaning EEPROM address width (array depth 2**AW bytes).
REQ-002 SHALL have port clk, input, 1, system clock (40 MHz).
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port SCLK, input, 1, SPI clock from master (clk/16), asynchronous to clk.
REQ-005 SHALL have port SS_n, input, 1, active-low slave select for this responder.
REQ-006 SHALL have port MOSI, input, 1, serial command from master, MSB first.
REQ-007 SHALL have port MISO, output, 1, serial response to master, MSB first; high-Z while SS_n high.
REQ-008 SHALL have port frame_done, output, 1, one-clk pulse on each accepted 16-bit frame.
REQ-009 SHALL have port frame_err, output, 1, one-clk pulse on each frame with bit count not equal to 16.
REQ-010 SHALL have port last_cmd, output, 16, last accepted command word.

Function
REQ-011 SHALL synchronize SCLK, SS_n and MOSI through two flops each before any use.
REQ-012 SHALL implement SPI mode 0: sample MOSI on synced SCLK rise and advance MISO on synced SCLK fall.
REQ-013 SHALL use FSM IDLE -> SHIFT on SS_n fall; SHIFT -> DONE on SS_n rise; DONE -> IDLE after one clk.
REQ-014 SHALL present response MSB on MISO before the first SCLK rise of a frame (load at SS_n fall).
REQ-015 SHALL count SCLK rises in a 5-bit saturating counter cleared at SS_n fall.
REQ-016 SHALL decode the command word as [15:14] op, [13:8] address (low AW bits used), [7:0] data.
REQ-017 SHALL implement op 00 as read: resp <= mem[addr].
REQ-018 SHALL implement op 01 as write: mem[addr] <= data; resp <= data (echo).
REQ-019 SHALL implement op 11 as no-op: resp <= 8'h00.
REQ-020 SHALL shift out {8'h00, resp} during frame N+1, where resp was computed in frame N (one-frame read latency).
REQ-021 SHALL, in DONE with count==16, execute the op, update last_cmd and pulse frame_done exactly once.
REQ-022 SHALL, in DONE with count!=16, leave mem, resp and last_cmd unchanged and pulse frame_err.
REQ-023 SHALL count an SCLK rise that is coincident with the SS_n rise (same synced cycle) before evaluating the count.
REQ-024 SHALL assert frame_done or frame_err no later than 4 clk after the pin-level SS_n rise.
REQ-025 SHALL ignore SCLK and MOSI activity while in IDLE.

Reset
REQ-026 SHALL on rst_n low force: state IDLE, counter 0, resp 8'h00, last_cmd 16'h0000, frame_done 0, frame_err 0, all mem bytes 8'h00, synchronizers to idle levels (SS_n=1, SCLK=0).
REQ-027 SHALL, when reset releases with SS_n already low, stay in IDLE until a fresh SS_n fall (partial frame discarded, no pulse).

Configuration
REQ-028 SHALL, with EEP_WP_EN defined, decode op 10 as write-protect set (wp <= data[0], resp <= {7'h0, data[0]}) and block op 01 writes while wp=1 (resp <= 8'hFF, mem unchanged); wp resets to 0.
REQ-029 SHALL, without EEP_WP_EN, treat op 10 as no-op (resp <= 8'h00) and never block writes.

Structure
REQ-030 SHALL place op encodings (OP_RD, OP_WR, OP_WP, OP_NOP), FSM state enum and frame length constant 16 in shared package dso_pkg.
REQ-031 SHALL factor the synchronizer plus edge detector into one sub-module spi_edge_sync, instantiated once per synchronized signal.

Verification
REQ-032 SHALL cover: write frame 16'h4A5C (addr 0x0A, data 0x5C), then read frame 16'h0A00, then no-op frame -> third frame MISO bits = 16'h005C.
REQ-033 SHALL cover: write frame 16'h4A5C followed immediately by any frame -> MISO = 16'h005C (echo), frame_done pulses twice.
REQ-034 SHALL cover: frame with 12 SCLK rises -> frame_err pulse, last_cmd unchanged, following read shows mem unchanged.
REQ-035 SHALL cover: rst_n low mid-frame after 8 bits, release with SS_n low -> no pulses until next full frame, then read of 0x0A returns 8'h00.
REQ-036 SHALL cover (EEP_WP_EN): frame 16'h8001, then write 16'h4A77, then read 0x0A -> write echo 8'hFF, read returns prior value 8'h00.
REQ-037 SHALL cover: final SCLK rise and SS_n rise in the same clk -> frame accepted, frame_done pulse within 4 clk.
